fcmp_pipe: RTL
==============

// Module: fcmp_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point compare/select unit for the ALU.
//  Executes EQ/LT/LE flags and MIN/MAX selection on two operands.
//  Uses a valid/ready handshake with a 2-cycle pipeline.
//  Preserves the established enable semantics: enable low forces a zero result.
// PARAMETERS
//  EXP_W   8   exponent field width
//  MAN_W   23  mantissa (fraction) field width; operand width W = 1+EXP_W+MAN_W (32 default)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  in_valid     in   1     operands/op valid
//  in_ready     out  1     unit accepts operands this cycle
//  read_data1   in   W     operand A {sign,exp,man}
//  read_data2   in   W     operand B
//  cmp_op       in   3     000 EQ, 001 LT, 010 LE, 011 MIN, 100 MAX, 101-111 reserved
//  cmp_en       in   1     enable; 0 -> result all zeros (transaction still flows)
//  out_valid    out  1     result valid
//  out_ready    in   1     consumer accepts result
//  cmp_data_out out  W     EQ/LT/LE: {W-1 zeros, flag}; MIN/MAX: selected operand
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, cmp_data_out=0, both stage valids cleared; async assert, sync-to-clk deassert usage.
//  - Stage 1 (S1): registers op, en, class bits (isNaN, isZero), sign, |magnitude| compare (A<B, A==B).
//  - Stage 2 (S2): forms result and holds it until the consumer takes it.
//  - Latency 2 cycles accept->out_valid; throughput 1/cycle with out_ready=1.
//  - Handshake: s2_adv = !s2_valid | out_ready; in_ready = !s1_valid | s2_adv.
//  - Accept on in_valid & in_ready.
//  - out_valid/cmp_data_out stable while out_valid & !out_ready; no drop, no duplicate.
//  - Ordering: sign-magnitude; +0 == -0 (EQ=1, LT=0, LE=1).
//  - Ordering: negatives reverse magnitude order; denormals ordered by raw bits.
//  - NaN = exp all ones & man!=0. Any NaN operand: EQ/LT/LE -> 0.
//  - NaN, MIN/MAX: exactly one NaN operand -> return the other operand.
//  - NaN, MIN/MAX: both NaN -> canonical qNaN {0, exp all ones, man MSB=1, rest 0}.
//  - MIN/MAX of +0/-0: MIN returns -0, MAX returns +0.
//  - Infinities order normally; +inf == +inf.
//  - Reserved cmp_op: result 0.
//  - cmp_en=0 overrides every op: result 0.
//  - Reset mid-operation: both stages flushed; in-flight results lost; out_valid=0 next edge.
//  - Simultaneous S2 drain and S1 refill in the same cycle is legal (full throughput).
// CONFIGURATION
//  FCMP_FLAGS_EN defined:
//   - adds out port cmp_invalid (1) and registered cmp_nv_sticky (1), plus in port flag_clr (1).
//   - cmp_invalid is registered alongside cmp_data_out.
//   - cmp_invalid=1 when: signalling NaN (man MSB=0) on any op; any NaN on LT/LE; reserved op.
//   - cmp_invalid is raised regardless of cmp_en.
//   - cmp_nv_sticky ORs cmp_invalid on each out handshake; flag_clr clears it; flag_clr wins when simultaneous.
//   - rst clears cmp_nv_sticky to 0.
//  FCMP_FLAGS_EN undefined: none of these ports or flag logic exist; datapath is identical.
// TESTING (default EXP_W=8, MAN_W=23)
//  - LE 0x40200000 vs 0x40200000 (2.5,2.5), en=1 -> out 0x00000001 two cycles after accept.
//  - LT 0x42B40000 vs 0x42F00000 (90<120) -> 1; LE 0xC3160000 vs 0x43160000 (-150<=150) -> 1.
//  - EQ 0x80000000 vs 0x00000000 -> 1.
//  - LE 58 vs 58 (0x42680000) with cmp_en=0 -> 0x00000000, out_valid still asserted.
//  - MAX 0xC28C0000 vs 0xC2A00000 (-70,-80) -> 0xC28C0000.
//  - MIN 0x7FC00000 vs 0x3F800000 -> 0x3F800000.
//  - LT with qNaN -> 0; FLAGS_EN: LT with qNaN -> cmp_invalid=1.
//  - 8 back-to-back ops, out_ready=0 for 5 cycles mid-stream.
//    -> in_ready drops after 2 queued; all 8 results in order, none duplicated.
//  - rst pulse with 2 ops in flight -> out_valid=0 after the edge; next op returns after exactly 2 cycles.

Source files
------------

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage IEEE-754-style compare/select unit (EQ/LT/LE/MIN/MAX) with valid/ready.
// Define FCMP_FLAGS_EN to add cmp_invalid, cmp_nv_sticky and flag_clr.
module fcmp_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   read_data1,
   input  logic [EXP_W+MAN_W:0]   read_data2,
   input  logic [2:0]             cmp_op,
   input  logic                   cmp_en,
`ifdef FCMP_FLAGS_EN
   input  logic                   flag_clr,
   output logic                   cmp_invalid,
   output logic                   cmp_nv_sticky,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   cmp_data_out
);

   localparam int W = 1 + EXP_W + MAN_W;

   localparam logic [2:0] OP_EQ  = 3'd0;
   localparam logic [2:0] OP_LT  = 3'd1;
   localparam logic [2:0] OP_LE  = 3'd2;
   localparam logic [2:0] OP_MIN = 3'd3;
   localparam logic [2:0] OP_MAX = 3'd4;

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic is_nan(input logic [W-1:0] x);
      return (&x[W-2:MAN_W]) & (|x[MAN_W-1:0]);
   endfunction

   function automatic logic is_zero(input logic [W-1:0] x);
      return ~|x[W-2:0];
   endfunction

   logic         s2_adv;
   logic         accept;

   logic         a_nan_d, b_nan_d, a_zero_d, b_zero_d, mag_lt_d, mag_eq_d;

   logic         s1_valid_q;
   logic [2:0]   s1_op_q;
   logic         s1_en_q;
   logic [W-1:0] s1_a_q, s1_b_q;
   logic         s1_a_nan_q, s1_b_nan_q;
   logic         s1_a_zero_q, s1_b_zero_q;
   logic         s1_mag_lt_q, s1_mag_eq_q;

   logic         any_nan, both_zero, same_sign, a_sign;
   logic         eq_v, lt_v, min_sel_a;
   logic [W-1:0] res_d;

   logic         s2_valid_q;
   logic [W-1:0] s2_data_q;

`ifdef FCMP_FLAGS_EN
   logic         a_snan_d, b_snan_d;
   logic         s1_a_snan_q, s1_b_snan_q;
   logic         inv_d;
   logic         s2_inv_q;
   logic         sticky_q;
`endif

   assign s2_adv       = !s2_valid_q | out_ready;
   assign in_ready     = !s1_valid_q | s2_adv;
   assign accept       = in_valid & in_ready;
   assign out_valid    = s2_valid_q;
   assign cmp_data_out = s2_data_q;

   // Stage 1: classify operands and compare magnitudes (sign stripped).
   always_comb begin
      a_nan_d  = is_nan(read_data1);
      b_nan_d  = is_nan(read_data2);
      a_zero_d = is_zero(read_data1);
      b_zero_d = is_zero(read_data2);
      mag_lt_d = read_data1[W-2:0] <  read_data2[W-2:0];
      mag_eq_d = read_data1[W-2:0] == read_data2[W-2:0];
   end

`ifdef FCMP_FLAGS_EN
   assign a_snan_d = a_nan_d & !read_data1[MAN_W-1];
   assign b_snan_d = b_nan_d & !read_data2[MAN_W-1];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= 3'd0;
         s1_en_q     <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_a_nan_q  <= 1'b0;
         s1_b_nan_q  <= 1'b0;
         s1_a_zero_q <= 1'b0;
         s1_b_zero_q <= 1'b0;
         s1_mag_lt_q <= 1'b0;
         s1_mag_eq_q <= 1'b0;
`ifdef FCMP_FLAGS_EN
         s1_a_snan_q <= 1'b0;
         s1_b_snan_q <= 1'b0;
`endif
      end else begin
         if (accept) begin
            s1_valid_q  <= 1'b1;
            s1_op_q     <= cmp_op;
            s1_en_q     <= cmp_en;
            s1_a_q      <= read_data1;
            s1_b_q      <= read_data2;
            s1_a_nan_q  <= a_nan_d;
            s1_b_nan_q  <= b_nan_d;
            s1_a_zero_q <= a_zero_d;
            s1_b_zero_q <= b_zero_d;
            s1_mag_lt_q <= mag_lt_d;
            s1_mag_eq_q <= mag_eq_d;
`ifdef FCMP_FLAGS_EN
            s1_a_snan_q <= a_snan_d;
            s1_b_snan_q <= b_snan_d;
`endif
         end else if (s2_adv) begin
            s1_valid_q  <= 1'b0;
         end
      end
   end

   // Stage 2: sign-magnitude ordering; negatives invert the magnitude order.
   always_comb begin
      any_nan   = s1_a_nan_q | s1_b_nan_q;
      both_zero = s1_a_zero_q & s1_b_zero_q;
      a_sign    = s1_a_q[W-1];
      same_sign = s1_a_q[W-1] == s1_b_q[W-1];
      eq_v      = !any_nan & (both_zero | (same_sign & s1_mag_eq_q));
      if (any_nan || both_zero) begin
         lt_v = 1'b0;
      end else if (!same_sign) begin
         lt_v = a_sign;
      end else if (a_sign) begin
         lt_v = !s1_mag_lt_q & !s1_mag_eq_q;
      end else begin
         lt_v = s1_mag_lt_q;
      end
      // On equality prefer the negative operand for MIN, which yields -0 for +0/-0.
      min_sel_a = lt_v | (eq_v & a_sign);

      res_d = '0;
      case (s1_op_q)
         OP_EQ: res_d[0] = eq_v;
         OP_LT: res_d[0] = lt_v;
         OP_LE: res_d[0] = lt_v | eq_v;
         OP_MIN, OP_MAX: begin
            if (s1_a_nan_q && s1_b_nan_q) begin
               res_d = QNAN;
            end else if (s1_a_nan_q) begin
               res_d = s1_b_q;
            end else if (s1_b_nan_q) begin
               res_d = s1_a_q;
            end else if (min_sel_a == (s1_op_q == OP_MIN)) begin
               res_d = s1_a_q;
            end else begin
               res_d = s1_b_q;
            end
         end
         default: res_d = '0;
      endcase
      if (!s1_en_q) begin
         res_d = '0;
      end
   end

`ifdef FCMP_FLAGS_EN
   assign inv_d = (s1_op_q > OP_MAX) | s1_a_snan_q | s1_b_snan_q |
                  (any_nan & ((s1_op_q == OP_LT) | (s1_op_q == OP_LE)));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
`ifdef FCMP_FLAGS_EN
         s2_inv_q   <= 1'b0;
`endif
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= res_d;
`ifdef FCMP_FLAGS_EN
            s2_inv_q  <= inv_d;
`endif
         end
      end
   end

`ifdef FCMP_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else if (flag_clr) begin
         sticky_q <= 1'b0;
      end else if (s2_valid_q && out_ready) begin
         sticky_q <= sticky_q | s2_inv_q;
      end
   end

   assign cmp_invalid   = s2_inv_q;
   assign cmp_nv_sticky = sticky_q;
`endif

endmodule
